// File: rtl/video_stream_monitor_pkg.sv
// Shared types and constants for the video stream monitor: pause FSM state
// encoding and the bit positions of the sticky error flags.
package video_stream_monitor_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } pause_state_e;

  localparam int unsigned ERR_EOL_EARLY   = 0;
  localparam int unsigned ERR_EOL_LATE    = 1;
  localparam int unsigned ERR_SOF_MIDLINE = 2;

endpackage

// File: rtl/video_stream_monitor_pause_injector.sv
// vsm_pause_injector: after every PAUSE_PERIOD accepted beats, optionally
// stalls the stream for exactly PAUSE_LEN clock cycles.
module vsm_pause_injector
  import video_stream_monitor_pkg::*;
#(
  parameter int unsigned PAUSE_PERIOD = 1000000,
  parameter int unsigned PAUSE_LEN    = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic beat_i,
  input  logic pause_enable_i,
  output logic pause_active_o
);

  localparam int unsigned BW = (PAUSE_PERIOD > 1) ? $clog2(PAUSE_PERIOD) : 1;
  localparam int unsigned LW = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(PAUSE_PERIOD - 1);
  localparam logic [LW-1:0] PLEN_LAST = LW'(PAUSE_LEN - 1);

  pause_state_e  state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] plen_q, plen_d;
  logic          pause_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    plen_d  = plen_q;
    case (state_q)
      ST_RUN: begin
        plen_d = '0;
        if (beat_i) begin
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (pause_enable_i && (PAUSE_LEN > 0)) begin
              state_d = ST_PAUSE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      // pause_enable is not looked at here, so a running pause always completes
      ST_PAUSE: begin
        if (plen_q == PLEN_LAST) begin
          state_d = ST_RUN;
          plen_d  = '0;
        end else begin
          plen_d = plen_q + LW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        plen_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      beat_q  <= '0;
      plen_q  <= '0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      plen_q  <= plen_d;
      pause_q <= (state_d == ST_PAUSE);
    end
  end

  assign pause_active_o = pause_q;

endmodule

// File: rtl/video_stream_monitor.sv
// Transparent AXI4-Stream video monitor: line/frame statistics, line-length and
// SOF checks, and optional pause injection (enabled by VSM_PAUSE_INJECT_EN).
module video_stream_monitor
  import video_stream_monitor_pkg::*;
#(
  parameter int unsigned DATA_W       = 96,
  parameter int unsigned LINE_W       = 12,
  parameter int unsigned CNT_W        = 30,
  parameter int unsigned PAUSE_PERIOD = 1000000,
  parameter int unsigned PAUSE_LEN    = 20
) (
  input  logic              s_axis_video_aclk,
  input  logic              s_axis_video_aresetn,
  input  logic [DATA_W-1:0] s_axis_video_tdata,
  input  logic              s_axis_video_tlast,
  input  logic              s_axis_video_tuser,
  input  logic              s_axis_video_tvalid,
  output logic              s_axis_video_tready,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tlast,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  input  logic              pause_enable,
  input  logic [LINE_W-1:0] cfg_line_len,
  input  logic              err_clr,
  output logic              pause_active,
  output logic [LINE_W-1:0] line_len,
  output logic [LINE_W-1:0] frame_lines,
  output logic [CNT_W-1:0]  frame_ticks,
  output logic [CNT_W-1:0]  frame_pixels,
  output logic [2:0]        err
);

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LINE_W-1:0] sat_line(input logic [LINE_W-1:0] v);
    return (&v) ? v : v + LINE_W'(1);
  endfunction

  logic beat_s;
  logic pause_s;

`ifdef VSM_PAUSE_INJECT_EN
  vsm_pause_injector #(
    .PAUSE_PERIOD (PAUSE_PERIOD),
    .PAUSE_LEN    (PAUSE_LEN)
  ) u_pause (
    .clk_i          (s_axis_video_aclk),
    .rst_ni         (s_axis_video_aresetn),
    .beat_i         (beat_s),
    .pause_enable_i (pause_enable),
    .pause_active_o (pause_s)
  );
`else
  logic            unused_pause_enable;
  localparam int unsigned UNUSED_PAUSE_CFG = PAUSE_PERIOD + PAUSE_LEN;
  assign unused_pause_enable = pause_enable;
  assign pause_s             = 1'b0;
`endif

  assign m_axis_video_tdata  = s_axis_video_tdata;
  assign m_axis_video_tlast  = s_axis_video_tlast;
  assign m_axis_video_tuser  = s_axis_video_tuser;
  assign m_axis_video_tvalid = s_axis_video_tvalid & ~pause_s;
  assign s_axis_video_tready = m_axis_video_tready & ~pause_s;
  assign beat_s              = m_axis_video_tvalid & m_axis_video_tready;
  assign pause_active        = pause_s;

  logic [CNT_W-1:0]  tick_q, tick_d, pix_q, pix_d;
  logic [CNT_W-1:0]  f_ticks_q, f_ticks_d, f_pix_q, f_pix_d;
  logic [LINE_W-1:0] col_q, col_d, line_q, line_d, line_base_s;
  logic [LINE_W-1:0] line_len_q, line_len_d, f_lines_q, f_lines_d;
  logic [LINE_W:0]   col_p1_s;
  logic [2:0]        err_q, err_d, err_set_s;

  assign col_p1_s = {1'b0, col_q} + (LINE_W + 1)'(1);

  always_comb begin
    tick_d      = sat_cnt(tick_q);
    pix_d       = pix_q;
    col_d       = col_q;
    line_d      = line_q;
    line_base_s = line_q;
    line_len_d  = line_len_q;
    f_lines_d   = f_lines_q;
    f_ticks_d   = f_ticks_q;
    f_pix_d     = f_pix_q;
    err_set_s   = 3'b000;
    if (beat_s) begin
      if (s_axis_video_tuser) begin
        f_pix_d     = pix_q;
        pix_d       = CNT_W'(1);
        f_lines_d   = line_q;
        line_base_s = '0;
        f_ticks_d   = tick_q;
        tick_d      = CNT_W'(1);
        err_set_s[ERR_SOF_MIDLINE] = (col_q != '0);
      end else begin
        pix_d       = sat_cnt(pix_q);
        line_base_s = line_q;
      end
      // a line that ends on the SOF beat is counted as the new frame's first line
      if (s_axis_video_tlast) begin
        line_len_d = sat_line(col_q);
        col_d      = '0;
        line_d     = sat_line(line_base_s);
      end else begin
        col_d      = sat_line(col_q);
        line_d     = line_base_s;
      end
      if (cfg_line_len != '0) begin
        err_set_s[ERR_EOL_EARLY] = s_axis_video_tlast && (col_p1_s < {1'b0, cfg_line_len});
        err_set_s[ERR_EOL_LATE]  = !s_axis_video_tlast && (col_p1_s == {1'b0, cfg_line_len});
      end else begin
        err_set_s[ERR_EOL_EARLY] = 1'b0;
        err_set_s[ERR_EOL_LATE]  = 1'b0;
      end
    end else begin
      err_set_s = 3'b000;
    end
    err_d = (err_clr ? 3'b000 : err_q) | err_set_s;
  end

  always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
    if (!s_axis_video_aresetn) begin
      tick_q     <= '0;
      pix_q      <= '0;
      col_q      <= '0;
      line_q     <= '0;
      line_len_q <= '0;
      f_lines_q  <= '0;
      f_ticks_q  <= '0;
      f_pix_q    <= '0;
      err_q      <= 3'b000;
    end else begin
      tick_q     <= tick_d;
      pix_q      <= pix_d;
      col_q      <= col_d;
      line_q     <= line_d;
      line_len_q <= line_len_d;
      f_lines_q  <= f_lines_d;
      f_ticks_q  <= f_ticks_d;
      f_pix_q    <= f_pix_d;
      err_q      <= err_d;
    end
  end

  assign line_len     = line_len_q;
  assign frame_lines  = f_lines_q;
  assign frame_ticks  = f_ticks_q;
  assign frame_pixels = f_pix_q;
  assign err          = err_q;

endmodule

// File: tb/tb_video_stream_monitor.sv
// Self-checking bench for video_stream_monitor: directed scenarios plus random
// traffic compared against an event-level reference model.
module tb_video_stream_monitor;

  localparam int DATA_W = 96;
  localparam int LINE_W = 12;
  localparam int CNT_W  = 30;
  localparam int PERIOD = 8;
  localparam int PLEN   = 3;
`ifdef VSM_PAUSE_INJECT_EN
  localparam bit PAUSE_BUILT = 1'b1;
`else
  localparam bit PAUSE_BUILT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              aresetn;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast, s_tuser, s_tvalid, s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast, m_tuser, m_tvalid, m_tready;
  logic              pause_enable, err_clr, pause_active;
  logic [LINE_W-1:0] cfg_line_len, line_len, frame_lines;
  logic [CNT_W-1:0]  frame_ticks, frame_pixels;
  logic [2:0]        err;

  int n_checks = 0;
  int n_fail   = 0;

  video_stream_monitor #(
    .DATA_W(DATA_W), .LINE_W(LINE_W), .CNT_W(CNT_W),
    .PAUSE_PERIOD(PERIOD), .PAUSE_LEN(PLEN)
  ) dut (
    .s_axis_video_aclk(clk), .s_axis_video_aresetn(aresetn),
    .s_axis_video_tdata(s_tdata), .s_axis_video_tlast(s_tlast),
    .s_axis_video_tuser(s_tuser), .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready),
    .m_axis_video_tdata(m_tdata), .m_axis_video_tlast(m_tlast),
    .m_axis_video_tuser(m_tuser), .m_axis_video_tvalid(m_tvalid),
    .m_axis_video_tready(m_tready),
    .pause_enable(pause_enable), .cfg_line_len(cfg_line_len), .err_clr(err_clr),
    .pause_active(pause_active), .line_len(line_len), .frame_lines(frame_lines),
    .frame_ticks(frame_ticks), .frame_pixels(frame_pixels), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: event-level bookkeeping of the stream
  int       m_col, m_lines, m_pix, m_ticks;
  int       m_line_len, m_frame_lines, m_frame_pix, m_frame_ticks;
  int       m_beats, m_pause_left;
  bit [2:0] m_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_lines = 0; m_pix = 0; m_ticks = 0;
    m_line_len = 0; m_frame_lines = 0; m_frame_pix = 0; m_frame_ticks = 0;
    m_beats = 0; m_pause_left = 0; m_err = 3'b000;
  endtask

  task automatic model_clock(input bit beat);
    bit [2:0] set = 3'b000;
    m_ticks++;
    if (beat) begin
      if (s_tuser) begin
        m_frame_pix   = m_pix;   m_pix = 1;
        m_frame_lines = m_lines; m_lines = 0;
        m_frame_ticks = m_ticks - 1; m_ticks = 1;
        if (m_col != 0) set[2] = 1'b1;
      end else begin
        m_pix++;
      end
      if (cfg_line_len != 0) begin
        if (s_tlast && (m_col + 1 < int'(cfg_line_len))) set[0] = 1'b1;
        if (!s_tlast && (m_col + 1 == int'(cfg_line_len))) set[1] = 1'b1;
      end
      if (s_tlast) begin
        m_line_len = m_col + 1; m_col = 0; m_lines++;
      end else begin
        m_col++;
      end
    end
    m_err = (err_clr ? 3'b000 : m_err) | set;
    if (PAUSE_BUILT) begin
      if (m_pause_left > 0) begin
        m_pause_left--;
      end else if (beat) begin
        m_beats++;
        if (m_beats == PERIOD) begin
          m_beats = 0;
          if (pause_enable) m_pause_left = PLEN;
        end
      end
    end
  endtask

  task automatic check_stats();
    chk("pause_active", pause_active, (m_pause_left > 0));
    chk("line_len", line_len, m_line_len);
    chk("frame_lines", frame_lines, m_frame_lines);
    chk("frame_ticks", frame_ticks, m_frame_ticks);
    chk("frame_pixels", frame_pixels, m_frame_pix);
    chk("err", err, m_err);
  endtask

  // One clock: inputs were set at the preceding negedge
  task automatic cycle();
    bit pa, beat;
    #1;
    pa   = (m_pause_left > 0);
    beat = s_tvalid & m_tready & !pa;
    chk("m_tvalid", m_tvalid, s_tvalid & !pa);
    chk("s_tready", s_tready, m_tready & !pa);
    chk("m_tdata", m_tdata, s_tdata);
    chk("m_side", {m_tlast, m_tuser}, {s_tlast, s_tuser});
    @(posedge clk);
    model_clock(beat);
    @(negedge clk);
    check_stats();
  endtask

  task automatic drive(input bit v, input bit u, input bit l);
    s_tvalid = v; s_tuser = u; s_tlast = l;
    s_tdata  = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic send_line(input int len, input bit sof, input bit clr_last);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, sof && (i == 0), i == len - 1);
      err_clr = clr_last && (i == len - 1);
      cycle();
    end
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      cycle();
    end
  endtask

  initial begin
    int pa_cnt, n_b;
    bit seen;
    aresetn = 1'b0; m_tready = 1'b1; pause_enable = 1'b0; err_clr = 1'b0;
    cfg_line_len = '0;
    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_stats();
    aresetn = 1'b1;

    // Transparency with pause injection on continuous traffic
    pause_enable = 1'b1;
    pa_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      cycle();
      if (pause_active === 1'b1) pa_cnt++;
    end
    chk("pause_cycles_24", pa_cnt, PAUSE_BUILT ? 6 : 0);
    pause_enable = 1'b0;
    idle(5);

    // Two 4x3 frames, then the next SOF
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < 3; l++) send_line(4, l == 0, 1'b0);
    chk("fr_line_len", line_len, 4);
    drive(1'b1, 1'b1, 1'b0);
    cycle();
    chk("fr_lines", frame_lines, 3);
    chk("fr_pixels", frame_pixels, 12);
    chk("fr_ticks", frame_ticks, 12);

    // Line-length checks
    cfg_line_len = LINE_W'(4);
    send_line(3, 1'b0, 1'b0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("err_cleared", err, 3'b000);
    send_line(3, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0);
    chk("err_early_late", err, 3'b011);
    send_line(2, 1'b0, 1'b1);
    chk("err_set_wins", err, 3'b001);

    // SOF mid-line, then odd lines with checks disabled
    cfg_line_len = '0;
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    drive(1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0); cycle();
    chk("err_sof_mid", err, 3'b100);
    send_line(1, 1'b0, 1'b0);
    send_line(3, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0);
    send_line(7, 1'b0, 1'b0);
    chk("err_cfg0", err, 3'b100);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
      m_tready     = ($urandom_range(0, 3) != 0);
      err_clr      = ($urandom_range(0, 29) == 0);
      pause_enable = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) cfg_line_len = LINE_W'($urandom_range(0, 6));
      cycle();
    end
    err_clr = 1'b0; m_tready = 1'b1;

    // Reset in the middle of a pause
    pause_enable = 1'b1;
    for (int i = 0; i < 30 && m_pause_left == 0; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      cycle();
    end
    chk("pause_reached", m_pause_left > 0, PAUSE_BUILT);
    #2 aresetn = 1'b0;
    model_reset();
    #1;
    check_stats();
    chk("rst_transparent", m_tvalid, s_tvalid);
    @(posedge clk);
    @(negedge clk);
    check_stats();
    aresetn = 1'b1;
    n_b = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      #1;
      if (s_tready === 1'b1) n_b++;
      cycle();
      if (pause_active === 1'b1) seen = 1'b1;
    end
    chk("beats_to_pause", seen ? n_b : 999, PAUSE_BUILT ? PERIOD : 999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
